// File: rtl/alu_dec_stage_pkg.sv
// Shared ALU / decode definitions: widths, ALU op codes, RV32I opcodes,
// operand-select codes and the registered decode payload.
package alu_dec_stage_pkg;

  localparam int unsigned CPU_WIDTH    = 32;
  localparam int unsigned INST_WIDTH   = 32;
  localparam int unsigned ALU_OP_WIDTH = 4;
  localparam int unsigned REG_AW       = 5;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQU  = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;
  localparam logic       SRC2_RS2  = 1'b0;
  localparam logic       SRC2_IMM  = 1'b1;

  typedef struct packed {
    alu_op_e               alu_op;
    logic [1:0]            src1_sel;
    logic                  src2_sel;
    logic [CPU_WIDTH-1:0]  imm;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
    logic                  rd_wen;
    logic                  br;
    logic                  br_inv;
    logic [CPU_WIDTH-1:0]  pc;
  } dec_t;

endpackage

// File: rtl/alu_dec_stage_if.sv
// Decode-stage bus: upstream valid/ready instruction input, downstream
// valid/ready decoded ALU control output, plus flush.
// master = producer/consumer side (bench or neighbour stages), slave = decode stage.
interface alu_dec_stage_if;
  import alu_dec_stage_pkg::*;

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [INST_WIDTH-1:0]   in_inst;
  logic [CPU_WIDTH-1:0]    in_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [ALU_OP_WIDTH-1:0] out_alu_op;
  logic [1:0]              out_src1_sel;
  logic                    out_src2_sel;
  logic [CPU_WIDTH-1:0]    out_imm;
  logic [REG_AW-1:0]       out_rs1;
  logic [REG_AW-1:0]       out_rs2;
  logic [REG_AW-1:0]       out_rd;
  logic                    out_rd_wen;
  logic                    out_br;
  logic                    out_br_inv;
  logic [CPU_WIDTH-1:0]    out_pc;
  logic                    out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_src1_sel, out_src2_sel,
           out_imm, out_rs1, out_rs2, out_rd, out_rd_wen, out_br,
           out_br_inv, out_pc, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_src1_sel, out_src2_sel,
           out_imm, out_rs1, out_rs2, out_rd, out_rd_wen, out_br,
           out_br_inv, out_pc, out_illegal
  );

endinterface

// File: rtl/alu_dec_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction (I/S/B/U/J), sign bit inst[31].
// Ports: inst (instruction word) in, imm (sign-extended immediate) out.
// Opcodes without an immediate yield zero.
module imm_gen
  import alu_dec_stage_pkg::*;
(
  input  logic [INST_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0]  imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_dec_stage.sv
// alu_dec_stage: decodes an RV32I instruction into ALU controls and holds the
// result in a one-entry valid/ready pipeline register (1-cycle latency).
// Ports: clk, rst (async, active-high), bus (alu_dec_stage_if.slave).
// Optional: define ALU_DEC_ILLEGAL_CHK_EN to flag illegal encodings on out_illegal.
module alu_dec_stage
  import alu_dec_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_dec_stage_if.slave   bus
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [CPU_WIDTH-1:0] imm_c;
  logic                 rd_wen_raw;
  logic                 accept;
  dec_t                 dec_c;
  dec_t                 dec_q;
  logic                 valid_q;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];

  imm_gen u_imm_gen (
    .inst (bus.in_inst),
    .imm  (imm_c)
  );

  // Instruction decode; unknown opcodes fall through as an ADD with no side effects.
  always_comb begin
    dec_c          = '0;
    dec_c.alu_op   = ALU_ADD;
    dec_c.src1_sel = SRC1_RS1;
    dec_c.src2_sel = SRC2_RS2;
    dec_c.imm      = imm_c;
    dec_c.rs1      = bus.in_inst[19:15];
    dec_c.rs2      = bus.in_inst[24:20];
    dec_c.rd       = bus.in_inst[11:7];
    dec_c.pc       = bus.in_pc;
    rd_wen_raw     = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        rd_wen_raw     = 1'b1;
        dec_c.src2_sel = (opcode == OPC_OP_IMM) ? SRC2_IMM : SRC2_RS2;
        case (funct3)
          3'b000: dec_c.alu_op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: dec_c.alu_op = ALU_SLL;
          3'b010: dec_c.alu_op = ALU_SLT;
          3'b011: dec_c.alu_op = ALU_SLTU;
          3'b100: dec_c.alu_op = ALU_XOR;
          3'b101: dec_c.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: dec_c.alu_op = ALU_OR;
          3'b111: dec_c.alu_op = ALU_AND;
          default: dec_c.alu_op = ALU_ADD;
        endcase
      end
      OPC_BRANCH: begin
        // funct3[0] selects the inverted sense (BNE/BGE/BGEU); 010/011 reserved -> NOP
        dec_c.br_inv = funct3[0];
        dec_c.br     = 1'b1;
        case (funct3[2:1])
          2'b00:   dec_c.alu_op = ALU_EQU;
          2'b10:   dec_c.alu_op = ALU_SLT;
          2'b11:   dec_c.alu_op = ALU_SLTU;
          default: begin
            dec_c.alu_op = ALU_ADD;
            dec_c.br     = 1'b0;
            dec_c.br_inv = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        rd_wen_raw     = 1'b1;
        dec_c.src1_sel = SRC1_ZERO;
        dec_c.src2_sel = SRC2_IMM;
      end
      OPC_AUIPC, OPC_JAL: begin
        rd_wen_raw     = 1'b1;
        dec_c.src1_sel = SRC1_PC;
        dec_c.src2_sel = SRC2_IMM;
      end
      OPC_LOAD, OPC_JALR: begin
        rd_wen_raw     = 1'b1;
        dec_c.src2_sel = SRC2_IMM;
      end
      OPC_STORE: begin
        dec_c.src2_sel = SRC2_IMM;
      end
      default: ;
    endcase
    dec_c.rd_wen = rd_wen_raw && (dec_c.rd != 5'd0);
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Pipeline register: flush beats load, load beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_alu_op   = dec_q.alu_op;
  assign bus.out_src1_sel = dec_q.src1_sel;
  assign bus.out_src2_sel = dec_q.src2_sel;
  assign bus.out_imm      = dec_q.imm;
  assign bus.out_rs1      = dec_q.rs1;
  assign bus.out_rs2      = dec_q.rs2;
  assign bus.out_rd       = dec_q.rd;
  assign bus.out_rd_wen   = dec_q.rd_wen;
  assign bus.out_br       = dec_q.br;
  assign bus.out_br_inv   = dec_q.br_inv;
  assign bus.out_pc       = dec_q.pc;

`ifdef ALU_DEC_ILLEGAL_CHK_EN
  logic illegal_c;
  logic illegal_q;

  // Flags unknown opcodes, bad funct7 on OP / shift-imm, and reserved branch funct3.
  always_comb begin
    illegal_c = 1'b0;
    case (opcode)
      OPC_OP:
        illegal_c = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          illegal_c = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal_c = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_BRANCH:
        illegal_c = (funct3[2:1] == 2'b01);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE:
        illegal_c = 1'b0;
      default:
        illegal_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (!bus.flush && accept) begin
      illegal_q <= illegal_c;
    end
  end

  assign bus.out_illegal = illegal_q;
`else
  assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dec_stage.sv
module tb_alu_dec_stage;
  import alu_dec_stage_pkg::*;

`ifdef ALU_DEC_ILLEGAL_CHK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  alu_dec_stage_if bus();

  alu_dec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] inst;
    alu_op_e     op;
    logic [1:0]  s1;
    logic        s2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic        inv;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] inst, input alu_op_e op,
                              input logic [1:0] s1, input logic s2, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic wen, input logic br, input logic inv, input logic ill);
    vec_t v;
    v.inst = inst; v.op = op; v.s1 = s1; v.s2 = s2; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen; v.br = br; v.inv = inv; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t v, input logic [31:0] pc);
    chk({tag, ".valid"},  32'(bus.out_valid),    32'd1);
    chk({tag, ".op"},     32'(bus.out_alu_op),   32'(v.op));
    chk({tag, ".src1"},   32'(bus.out_src1_sel), 32'(v.s1));
    chk({tag, ".src2"},   32'(bus.out_src2_sel), 32'(v.s2));
    chk({tag, ".imm"},    bus.out_imm,           v.imm);
    chk({tag, ".rs1"},    32'(bus.out_rs1),      32'(v.rs1));
    chk({tag, ".rs2"},    32'(bus.out_rs2),      32'(v.rs2));
    chk({tag, ".rd"},     32'(bus.out_rd),       32'(v.rd));
    chk({tag, ".rd_wen"}, 32'(bus.out_rd_wen),   32'(v.wen));
    chk({tag, ".br"},     32'(bus.out_br),       32'(v.br));
    chk({tag, ".br_inv"}, 32'(bus.out_br_inv),   32'(v.inv));
    chk({tag, ".pc"},     bus.out_pc,            pc);
    chk({tag, ".illegal"},32'(bus.out_illegal),  32'(v.ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            inst          op        s1         s2        imm           rs1    rs2    rd     wen   br    inv   ill
    vecs[0]  = mk(32'h00500093, ALU_ADD,  SRC1_RS1,  SRC2_IMM, 32'h00000005, 5'd0,  5'd5,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0);   // ADDI x1,x0,5
    vecs[1]  = mk(32'h402081B3, ALU_SUB,  SRC1_RS1,  SRC2_RS2, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0);   // SUB x3,x1,x2
    vecs[2]  = mk(32'h40335293, ALU_SRA,  SRC1_RS1,  SRC2_IMM, 32'h00000403, 5'd6,  5'd3,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0);   // SRAI x5,x6,3
    vecs[3]  = mk(32'h00209463, ALU_EQU,  SRC1_RS1,  SRC2_RS2, 32'h00000008, 5'd1,  5'd2,  5'd8,  1'b0, 1'b1, 1'b1, 1'b0);   // BNE x1,x2,+8
    vecs[4]  = mk(32'hFE41DEE3, ALU_SLT,  SRC1_RS1,  SRC2_RS2, 32'hFFFFFFFC, 5'd3,  5'd4,  5'd29, 1'b0, 1'b1, 1'b1, 1'b0);   // BGE x3,x4,-4
    vecs[5]  = mk(32'hABCDE3B7, ALU_ADD,  SRC1_ZERO, SRC2_IMM, 32'hABCDE000, 5'd27, 5'd28, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0);   // LUI x7
    vecs[6]  = mk(32'h00001017, ALU_ADD,  SRC1_PC,   SRC2_IMM, 32'h00001000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0);   // AUIPC x0 (rd=0)
    vecs[7]  = mk(32'hFE512C23, ALU_ADD,  SRC1_RS1,  SRC2_IMM, 32'hFFFFFFF8, 5'd2,  5'd5,  5'd24, 1'b0, 1'b0, 1'b0, 1'b0);   // SW x5,-8(x2)
    vecs[8]  = mk(32'h7FF0A503, ALU_ADD,  SRC1_RS1,  SRC2_IMM, 32'h000007FF, 5'd1,  5'd31, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);   // LW x10,2047(x1)
    vecs[9]  = mk(32'h0062B233, ALU_SLTU, SRC1_RS1,  SRC2_RS2, 32'h00000000, 5'd5,  5'd6,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0);   // SLTU x4,x5,x6
    vecs[10] = mk(32'hFFF4C413, ALU_XOR,  SRC1_RS1,  SRC2_IMM, 32'hFFFFFFFF, 5'd9,  5'd31, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0);   // XORI x8,x9,-1
    vecs[11] = mk(32'hFFFFFFFF, ALU_ADD,  SRC1_RS1,  SRC2_RS2, 32'h00000000, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, ILL_EN); // unknown opcode
    vecs[12] = mk(32'h023110B3, ALU_SLL,  SRC1_RS1,  SRC2_RS2, 32'h00000000, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, ILL_EN); // SLL with funct7=1
    vecs[13] = mk(32'h0041F133, ALU_AND,  SRC1_RS1,  SRC2_RS2, 32'h00000000, 5'd3,  5'd4,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0);   // AND x2,x3,x4

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;

    // reset state
    #3;
    chk("rst.valid",    32'(bus.out_valid),   32'd0);
    chk("rst.op",       32'(bus.out_alu_op),  32'(ALU_ADD));
    chk("rst.in_ready", 32'(bus.in_ready),    32'd1);
    chk("rst.imm",      bus.out_imm,          32'd0);
    chk("rst.rd_wen",   32'(bus.out_rd_wen),  32'd0);
    chk("rst.illegal",  32'(bus.out_illegal), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // back-to-back stream at full throughput
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = vecs[i].inst;
      bus.in_pc    = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i], 32'h1000 + 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(bus.out_valid), 32'd0);

    // stall: BNE held for 3 cycles while ADDI waits upstream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = vecs[3].inst;
    bus.in_pc     = 32'h200;
    tick();
    chk_out("stall0", vecs[3], 32'h200);
    bus.in_inst = vecs[0].inst;
    bus.in_pc   = 32'h204;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
      tick();
      chk_out($sformatf("stall%0d", c), vecs[3], 32'h200);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk_out("release", vecs[0], 32'h204);

    // flush with a held entry and a concurrent input
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_inst   = vecs[1].inst;
    bus.in_pc     = 32'h300;
    tick();
    chk("flush.valid", 32'(bus.out_valid), 32'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("flush.dropped", 32'(bus.out_valid), 32'd0);

    // async reset in the middle of a stall
    bus.in_valid = 1'b1;
    bus.in_inst  = vecs[1].inst;
    bus.in_pc    = 32'h400;
    tick();
    chk_out("prerst", vecs[1], 32'h400);
    bus.in_valid = 1'b0;
    tick();
    chk("prerst.hold", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.valid",    32'(bus.out_valid),  32'd0);
    chk("midrst.op",       32'(bus.out_alu_op), 32'(ALU_ADD));
    chk("midrst.in_ready", 32'(bus.in_ready),   32'd1);
    chk("midrst.rd_wen",   32'(bus.out_rd_wen), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst.valid", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_dec_stage.md
ALU_DEC_STAGE -- requirements
Module: alu_dec_stage

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); rst input 1 (asynchronous, active-high).
REQ-002 SHALL have ports: flush input 1 (drops held entry); in_valid input 1; in_ready output 1; in_inst input 32 (RV32I instruction); in_pc input `CPU_WIDTH.
REQ-003 SHALL have ports: out_valid output 1; out_ready input 1; out_alu_op output `ALU_OP_WIDTH; out_src1_sel output 2 (0=rs1, 1=pc, 2=zero); out_src2_sel output 1 (0=rs2, 1=imm).
REQ-004 SHALL have ports: out_imm output `CPU_WIDTH (sign-extended); out_rs1, out_rs2, out_rd output 5 each; out_rd_wen output 1; out_br output 1; out_br_inv output 1 (taken when ALU result bit0 is 0); out_pc output `CPU_WIDTH; out_illegal output 1.

Function
REQ-005 SHALL decode in_inst into the ALU op encoding consumed by the ALU and register every output in a one-entry pipeline register; latency exactly 1 cycle from accepted input to out_valid.
REQ-006 SHALL accept input when in_valid && in_ready; in_ready SHALL be !out_valid || out_ready (combinational, no bubble at full throughput).
REQ-007 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-008 SHALL clear out_valid after out_valid && out_ready when no new input is accepted in the same cycle.
REQ-009 Simultaneous output handshake and input accept SHALL load the new entry (out_valid stays 1).
REQ-010 flush SHALL clear out_valid next cycle and discard any input accepted in the same cycle; flush has priority over all other updates.
REQ-011 OP-IMM/OP: funct3 000 -> ALU_ADD (OP with funct7[5]=1 -> ALU_SUB), 001 -> ALU_SLL, 010 -> ALU_SLT, 011 -> ALU_SLTU, 100 -> ALU_XOR, 101 -> ALU_SRL / ALU_SRA (funct7[5]), 110 -> ALU_OR, 111 -> ALU_AND; src2_sel=1 for OP-IMM; rd_wen=1.
REQ-012 BRANCH: BEQ/BNE -> ALU_EQU, BLT/BGE -> ALU_SLT, BLTU/BGEU -> ALU_SLTU; br=1; br_inv=1 for BNE/BGE/BGEU; rd_wen=0; src2_sel=0.
REQ-013 LUI -> ALU_ADD, src1_sel=2, imm={inst[31:12],12'b0}; AUIPC -> ALU_ADD, src1_sel=1, same imm; LOAD/STORE/JALR -> ALU_ADD, src2_sel=1 with I/S immediate; STORE and BRANCH rd_wen=0.
REQ-014 Immediates: I, S, B, U formats per RV32I, sign bit inst[31]; shift immediates pass inst[24:20] in imm[4:0]; rd_wen forced 0 when rd=0.
REQ-015 Undecodable opcode SHALL produce alu_op=ALU_ADD, rd_wen=0, br=0 (architectural NOP).

Reset
REQ-016 On rst: out_valid=0, out_alu_op=ALU_ADD, all other registered outputs 0; in_ready=1 while reset held; reset mid-transfer discards held entry.

Configuration
REQ-017 With ALU_DEC_ILLEGAL_CHK_EN defined: out_illegal=1 for unknown opcode, bad funct7 on OP/shift-imm, or funct3 010/011 on BRANCH; decode still per REQ-015.
REQ-018 Without ALU_DEC_ILLEGAL_CHK_EN: out_illegal tied 0, no check logic synthesised.

Structure
REQ-019 ALU_OP_WIDTH, CPU_WIDTH, ALU_* op codes, RV32I opcode constants and src-select codes SHALL come from the shared define package used by the ALU; no local redefinition.
REQ-020 Immediate generation SHALL be one sub-module, imm_gen (combinational, inst in, imm out); decode logic combinational, registers only in top.

Verification
REQ-021 ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, ALU_ADD, src2_sel=1, imm=5, rd=1, rd_wen=1.
REQ-022 SUB x3,x1,x2 (0x402081B3) then SRAI x5,x6,3 (0x40335293) back-to-back -> ALU_SUB then ALU_SRA imm[4:0]=3, no bubble, in_ready=1 throughout.
REQ-023 BNE with out_ready=0 for 3 cycles -> outputs held stable, in_ready=0; next instruction accepted cycle out_ready rises; ALU_EQU, br=1, br_inv=1.
REQ-024 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input dropped.
REQ-025 0xFFFFFFFF with ALU_DEC_ILLEGAL_CHK_EN -> out_illegal=1, rd_wen=0; without macro -> out_illegal=0.
REQ-026 rst asserted mid-stall -> out_valid=0 immediately (async), out_alu_op=ALU_ADD.
